best_hop_scanner: RTL
=====================

# best_hop_scanner

Front end of the Q-routing decision path: on each `start` it reads a destination's per-neighbor Q-values (16-bit half-precision floats) from the Q-table RAM, finds the minimum and the neighbor that holds it, and latches the advertised best from the incoming packet. It then presents `mybest`, `besthop`, `bestvalue` and `bestneighborID` with a one-cycle `done` pulse, which drives `done_prev` of the epsilon-greedy policy block.

## Interface
- `ADDR_W`, 10, Q-table RAM address width (1024 words).
- `IDX_W`, 3, neighbor index width; `NEIGHBOR_MAX` = 2**`IDX_W` = 8.
- `WORD_W`, 16, Q-value / node-ID width.
- `clock`  in  1  clock.
- `nreset`  in  1  reset: synchronous, active-low, sampled on `clock`.
- `start`  in  1  request; sampled only in IDLE.
- `dest_id`  in  16  destination; low `ADDR_W-IDX_W` bits select the table row.
- `neighbor_count`  in  `IDX_W+1`  number of valid neighbors; values above `NEIGHBOR_MAX` clamp to `NEIGHBOR_MAX`.
- `nbr_ids`  in  `NEIGHBOR_MAX*16`  neighbor IDs; entry i is bits [16i+15:16i]; must be stable while `busy`.
- `adv_value`  in  16  fp16 best value advertised in the received packet.
- `adv_id`  in  16  ID of the neighbor that advertised `adv_value`.
- `mem_rd`  out  1  RAM read strobe.
- `mem_addr`  out  `ADDR_W`  RAM address, {`dest_id[ADDR_W-IDX_W-1:0]`, idx}.
- `mem_rdata`  in  16  RAM data; valid exactly 1 cycle after `mem_rd`.
- `mybest`  out  16  minimum local Q-value (fp16).
- `besthop`  out  16  neighbor ID holding `mybest`.
- `bestvalue`  out  16  latched `adv_value`.
- `bestneighborID`  out  16  latched `adv_id`.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse; outputs are valid in the same cycle.

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: if `start`, latch `dest_id`, the clamped count N, `adv_value` and `adv_id`. Reset the running minimum to +inf (0x7C00) and the running hop to 16'hFFFF. Go to READ, or go to DONE if N == 0.
- READ: assert `mem_rd` with idx = 0..N-1, one per cycle. After issuing idx N-1, go to DRAIN.
- Compare stage, active every cycle after a read: if `mem_rdata` < running minimum (strict fp16 less-than), update the minimum and set the hop to `nbr_ids[idx_d]`, where `idx_d` is the delayed index. Ties keep the lower index.
- DRAIN: perform the final compare, then go to DONE.
- DONE: register the minimum, hop and latched advert into the outputs, pulse `done`, return to IDLE.
- fp16 less-than:
  - Differing signs: the negative operand is smaller, except +0 and -0 compare equal.
  - Both positive: unsigned compare of bits [14:0].
  - Both negative: reversed unsigned compare of bits [14:0].
- `start` while `busy` is ignored, with no queueing.
- Outputs hold their values between DONE cycles and change only in DONE.
- Empty row (N == 0): no RAM reads; `mybest` = 0x7C00, `besthop` = 16'hFFFF, `done` still pulses.
- Reset mid-operation: return to IDLE, drive all outputs to reset values, and do not pulse `done`.

## Timing
- Reset values: `mem_rd` 0, `mem_addr` 0, `mybest` 0x7C00, `besthop` 16'hFFFF, `bestvalue` 0, `bestneighborID` 0, `busy` 0, `done` 0.
- `start` is sampled at edge 0. Reads are issued in cycles 1..N, compares happen in cycles 2..N+1, and `done` is high in cycle N+2.
- N == 0: `done` is high in cycle 1.
- The earliest next `start` is accepted in cycle N+3 (back in IDLE).
- `mem_addr` and `mem_rd` are registered outputs; the compare uses `mem_rdata` combinationally and registers the result.

## Configuration
- `QSCAN_SKIP_NAN_EN` defined: a word with exponent 5'h1F and nonzero mantissa is never selected. If every entry is NaN, the empty-row values are output.
- `QSCAN_SKIP_NAN_EN` undefined: NaNs go through the comparator bit pattern unchanged, so a positive NaN never wins and a negative NaN does.

## Structure
- Package `qrouting_pkg` holds:
  - `FP16_POS_INF` (16'h7C00), `FP16_ZERO`, `NO_HOP` (16'hFFFF)
  - default `IDX_W` / `ADDR_W`
  - state encoding typedef
  - these are shared with the policy block
- Sub-module `fp16_less`: combinational, inputs a and b, output lt. It is reused later by the policy to replace its subtractor-based compares.

## Test plan
- N=4, row Q = {0x4000, 0x3800, 0x3C00, 0x4200}, ids {11,12,13,14} -> `done` at cycle 6, `mybest` 0x3800, `besthop` 12.
- N=3, Q = {0x3C00, 0x3C00, 0x4000}, ids {5,6,7} -> tie resolves to `besthop` 5, `mybest` 0x3C00.
- N=2, Q = {0x8000, 0x0000} -> `mybest` 0x8000 (index 0 kept, ±0 equal); Q = {0x3C00, 0xBC00} -> `mybest` 0xBC00.
- N=0, `adv_value` 0x3E00, `adv_id` 9 -> no `mem_rd`, `done` at cycle 1, `mybest` 0x7C00, `besthop` 0xFFFF, `bestvalue` 0x3E00, `bestneighborID` 9.
- N=8 scan with `nreset` low at cycle 4 -> all outputs at reset values, no `done`. A new `start` after reset completes normally. `start` asserted while busy has no effect.
- `QSCAN_SKIP_NAN_EN` defined, N=2, Q = {0xFE01, 0x4000} -> `mybest` 0x4000, `besthop` = id[1].

Source files
------------

// File: rtl/qrouting_pkg.sv
// Shared Q-routing definitions: fp16 constants, default widths and the
// scanner state encoding. Also used by the epsilon-greedy policy block.
package qrouting_pkg;

   localparam int unsigned DEF_ADDR_W = 10;
   localparam int unsigned DEF_IDX_W  = 3;
   localparam int unsigned DEF_WORD_W = 16;

   localparam logic [15:0] FP16_POS_INF = 16'h7C00;
   localparam logic [15:0] FP16_ZERO    = 16'h0000;
   localparam logic [15:0] NO_HOP       = 16'hFFFF;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StDrain,
      StDone
   } scan_state_e;

   // Exponent all ones with a nonzero mantissa.
   function automatic logic fp16_is_nan(input logic [15:0] v);
      return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
   endfunction

endpackage

// File: rtl/fp16_less.sv
// Combinational strict less-than on fp16 bit patterns. +0 and -0 compare
// equal; NaNs are ordered purely by their bit pattern.
module fp16_less
   import qrouting_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        lt
);

   // Sign-magnitude ordering with the signed-zero special case.
   always_comb begin
      lt = 1'b0;
      if ((a[14:0] == 15'd0) && (b[14:0] == 15'd0)) begin
         lt = 1'b0;
      end else if (a[15] != b[15]) begin
         lt = a[15];
      end else if (!a[15]) begin
         lt = (a[14:0] < b[14:0]);
      end else begin
         lt = (a[14:0] > b[14:0]);
      end
   end

endmodule

// File: rtl/best_hop_scanner.sv
// Q-routing best-hop scanner: reads one Q-table row, finds the minimum fp16
// Q-value and its neighbor, and latches the packet's advertised best.
// Optional feature macro: QSCAN_SKIP_NAN_EN (NaN entries are never selected).
module best_hop_scanner
   import qrouting_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned IDX_W  = DEF_IDX_W,
   parameter int unsigned WORD_W = DEF_WORD_W
) (
   input  logic                                clock,
   input  logic                                nreset,
   input  logic                                start,
   input  logic [WORD_W-1:0]                   dest_id,
   input  logic [IDX_W:0]                      neighbor_count,
   input  logic [(2**IDX_W)*WORD_W-1:0]        nbr_ids,
   input  logic [WORD_W-1:0]                   adv_value,
   input  logic [WORD_W-1:0]                   adv_id,
   output logic                                mem_rd,
   output logic [ADDR_W-1:0]                   mem_addr,
   input  logic [WORD_W-1:0]                   mem_rdata,
   output logic [WORD_W-1:0]                   mybest,
   output logic [WORD_W-1:0]                   besthop,
   output logic [WORD_W-1:0]                   bestvalue,
   output logic [WORD_W-1:0]                   bestneighborID,
   output logic                                busy,
   output logic                                done
);

   localparam int unsigned NEIGHBOR_MAX = 2 ** IDX_W;
   localparam int unsigned ROW_W        = ADDR_W - IDX_W;
   localparam logic [IDX_W:0]   CountMax = (IDX_W+1)'(NEIGHBOR_MAX);
   localparam logic [IDX_W-1:0] IdxOne   = IDX_W'(1);

   scan_state_e        r_state;
   logic [ROW_W-1:0]   r_row;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   r_idx_d;
   logic [IDX_W-1:0]   r_last;
   logic               r_cmp_valid;
   logic [WORD_W-1:0]  r_min;
   logic [WORD_W-1:0]  r_hop;
   logic [WORD_W-1:0]  r_adv_value;
   logic [WORD_W-1:0]  r_adv_id;

   logic               r_mem_rd;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [WORD_W-1:0]  r_mybest;
   logic [WORD_W-1:0]  r_besthop;
   logic [WORD_W-1:0]  r_bestvalue;
   logic [WORD_W-1:0]  r_bestnbr;
   logic               r_busy;
   logic               r_done;

   logic [IDX_W:0]     w_count;
   logic               w_lt;
   logic               w_skip;
   logic               w_take;
   logic [WORD_W-1:0]  w_min_next;
   logic [WORD_W-1:0]  w_hop_next;
   logic [WORD_W-1:0]  w_ids [NEIGHBOR_MAX];
   logic               w_unused_dest;

   assign w_unused_dest = ^dest_id[WORD_W-1:ROW_W];

   for (genvar gi = 0; gi < NEIGHBOR_MAX; gi++) begin : g_ids
      assign w_ids[gi] = nbr_ids[gi*WORD_W +: WORD_W];
   end

   fp16_less u_less (
      .a  (mem_rdata),
      .b  (r_min),
      .lt (w_lt)
   );

   // Clamp the requested neighbor count to the table width.
   always_comb begin
      w_count = neighbor_count;
      if (neighbor_count > CountMax) begin
         w_count = CountMax;
      end
   end

   // Compare stage: the word read last cycle replaces the running minimum
   // only when strictly smaller, so ties keep the lower index.
   always_comb begin
`ifdef QSCAN_SKIP_NAN_EN
      w_skip = fp16_is_nan(mem_rdata);
`else
      w_skip = 1'b0;
`endif
      w_take     = r_cmp_valid && w_lt && !w_skip;
      w_min_next = w_take ? mem_rdata : r_min;
      w_hop_next = w_take ? w_ids[r_idx_d] : r_hop;
   end

   // Scan FSM with registered RAM strobes and result outputs.
   always_ff @(posedge clock) begin
      if (!nreset) begin
         r_state     <= StIdle;
         r_row       <= '0;
         r_idx       <= '0;
         r_idx_d     <= '0;
         r_last      <= '0;
         r_cmp_valid <= 1'b0;
         r_min       <= FP16_POS_INF;
         r_hop       <= NO_HOP;
         r_adv_value <= '0;
         r_adv_id    <= '0;
         r_mem_rd    <= 1'b0;
         r_mem_addr  <= '0;
         r_mybest    <= FP16_POS_INF;
         r_besthop   <= NO_HOP;
         r_bestvalue <= '0;
         r_bestnbr   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_min       <= w_min_next;
         r_hop       <= w_hop_next;
         r_cmp_valid <= r_mem_rd;
         r_idx_d     <= r_idx;
         r_done      <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (start) begin
                  r_row       <= dest_id[ROW_W-1:0];
                  r_last      <= w_count[IDX_W-1:0] - IdxOne;
                  r_adv_value <= adv_value;
                  r_adv_id    <= adv_id;
                  r_min       <= FP16_POS_INF;
                  r_hop       <= NO_HOP;
                  r_busy      <= 1'b1;
                  if (w_count == '0) begin
                     // Empty row: publish the neutral result straight away.
                     r_mybest    <= FP16_POS_INF;
                     r_besthop   <= NO_HOP;
                     r_bestvalue <= adv_value;
                     r_bestnbr   <= adv_id;
                     r_done      <= 1'b1;
                     r_state     <= StDone;
                  end else begin
                     r_idx      <= '0;
                     r_mem_rd   <= 1'b1;
                     r_mem_addr <= {dest_id[ROW_W-1:0], {IDX_W{1'b0}}};
                     r_state    <= StRead;
                  end
               end
            end
            StRead: begin
               if (r_idx == r_last) begin
                  r_mem_rd <= 1'b0;
                  r_state  <= StDrain;
               end else begin
                  r_idx      <= r_idx + IdxOne;
                  r_mem_addr <= {r_row, r_idx + IdxOne};
               end
            end
            StDrain: begin
               // Last read's compare result goes straight to the outputs.
               r_mybest    <= w_min_next;
               r_besthop   <= w_hop_next;
               r_bestvalue <= r_adv_value;
               r_bestnbr   <= r_adv_id;
               r_done      <= 1'b1;
               r_state     <= StDone;
            end
            StDone: begin
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign mem_rd         = r_mem_rd;
   assign mem_addr       = r_mem_addr;
   assign mybest         = r_mybest;
   assign besthop        = r_besthop;
   assign bestvalue      = r_bestvalue;
   assign bestneighborID = r_bestnbr;
   assign busy           = r_busy;
   assign done           = r_done;

endmodule
